// File: rtl/rom_load_sequencer.sv
// ROM download sequencer: decodes the HPS byte stream into region write strobes, validates the
// image length and owns the core reset, releasing it a fixed delay after a good load.
module rom_load_sequencer #(
  parameter logic [15:0] SND_BASE    = 16'h4000,
  parameter logic [15:0] GFX_BASE    = 16'h5800,
  parameter logic [15:0] PROM_BASE   = 16'h6800,
  parameter logic [15:0] IMG_END     = 16'h6820,
  parameter int unsigned HOLD_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        RESET_N,
  input  logic        dn_download,
  input  logic        dn_wr,
  input  logic [24:0] dn_addr,
  input  logic [7:0]  dn_data,
  input  logic        ext_reset,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        we_cpu,
  output logic        we_snd,
  output logic        we_gfx,
  output logic        we_prom,
  output logic        core_reset,
  output logic        load_done,
  output logic        load_err,
  output logic [16:0] byte_count
);

  localparam int unsigned   CntW     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(HOLD_CYCLES - 1);
  localparam logic [16:0]   CountMax = 17'h1FFFF;
  localparam logic [16:0]   ImgLen   = {1'b0, IMG_END};

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCheck,
    StHold,
    StRun,
    StFail
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            dl_q;
  logic            oor_q, oor_d;
  logic            load_done_q, load_done_d;
  logic            load_err_q, load_err_d;
  logic [16:0]     byte_count_q, byte_count_d;
  logic [3:0]      we_q, we_d;
  logic [15:0]     wr_addr_q, wr_addr_d;
  logic [7:0]      wr_data_q, wr_data_d;

  logic        dl_rise;
  logic        accept;
  logic        in_range;
  logic [15:0] addr_lo;
  logic [3:0]  region_sel;
  logic [15:0] region_base;

  assign addr_lo  = dn_addr[15:0];
  assign dl_rise  = dn_download & ~dl_q;
  // LOAD still accepts a strobe on the cycle the download window closes.
  assign accept   = dn_wr & (dn_download | (state_q == StLoad));
  assign in_range = (dn_addr[24:16] == 9'd0) && (addr_lo < IMG_END);

  // Region decode: one-hot select {prom, gfx, snd, cpu} and the base to subtract.
  always_comb begin
    region_sel  = 4'b0000;
    region_base = 16'h0000;
    if (addr_lo < SND_BASE) begin
      region_sel  = 4'b0001;
      region_base = 16'h0000;
    end else if (addr_lo < GFX_BASE) begin
      region_sel  = 4'b0010;
      region_base = SND_BASE;
    end else if (addr_lo < PROM_BASE) begin
      region_sel  = 4'b0100;
      region_base = GFX_BASE;
    end else begin
      region_sel  = 4'b1000;
      region_base = PROM_BASE;
    end
  end

  // Write path and image bookkeeping.
  always_comb begin
    we_d         = 4'b0000;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    byte_count_d = dl_rise ? 17'd0 : byte_count_q;
    oor_d        = dl_rise ? 1'b0 : oor_q;
    if (accept) begin
      if (in_range) begin
        we_d      = region_sel;
        wr_addr_d = addr_lo - region_base;
        wr_data_d = dn_data;
        if (byte_count_d != CountMax) begin
          byte_count_d = byte_count_d + 17'd1;
        end
      end else begin
        oor_d = 1'b1;
      end
    end
  end

  // Sequencer next state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    load_done_d = load_done_q;
    load_err_d  = load_err_q;
    unique case (state_q)
      StIdle: begin
      end
      StLoad: begin
        if (!dn_download) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        if ((byte_count_q == ImgLen) && !oor_q) begin
          load_done_d = 1'b1;
          state_d     = StHold;
          cnt_d       = CntLoad;
        end else begin
          load_err_d = 1'b1;
          state_d    = StFail;
        end
      end
      StHold: begin
        if (ext_reset) begin
          cnt_d = CntLoad;
        end else if (cnt_q == '0) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StRun: begin
        if (ext_reset) begin
          state_d = StHold;
          cnt_d   = CntLoad;
        end
      end
      StFail: begin
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    // A new download window overrides everything, including a pending hold or failure.
    if (dl_rise) begin
      state_d     = StLoad;
      load_done_d = 1'b0;
      load_err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      dl_q         <= 1'b0;
      oor_q        <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
      byte_count_q <= 17'd0;
      we_q         <= 4'b0000;
      wr_addr_q    <= 16'h0000;
      wr_data_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dl_q         <= dn_download;
      oor_q        <= oor_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
      byte_count_q <= byte_count_d;
      we_q         <= we_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign we_cpu     = we_q[0];
  assign we_snd     = we_q[1];
  assign we_gfx     = we_q[2];
  assign we_prom    = we_q[3];
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign byte_count = byte_count_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;
  assign core_reset = (state_q != StRun);

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Directed-sequence bench for rom_load_sequencer with random data/gaps checked against an
// address-map reference model.
module tb_rom_load_sequencer;

  localparam int unsigned Hold   = 16;
  localparam int unsigned ImgEnd = 32'h6820;

  logic        clk = 1'b0;
  logic        RESET_N;
  logic        dn_download;
  logic        dn_wr;
  logic [24:0] dn_addr;
  logic [7:0]  dn_data;
  logic        ext_reset;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        we_cpu, we_snd, we_gfx, we_prom;
  logic        core_reset, load_done, load_err;
  logic [16:0] byte_count;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state.
  logic        prev_dl;
  logic [16:0] m_count;
  logic [15:0] m_addr;
  logic [7:0]  m_data;

  always #5 clk = ~clk;

  rom_load_sequencer #(.HOLD_CYCLES(Hold)) dut (
    .clk        (clk),
    .RESET_N    (RESET_N),
    .dn_download(dn_download),
    .dn_wr      (dn_wr),
    .dn_addr    (dn_addr),
    .dn_data    (dn_data),
    .ext_reset  (ext_reset),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .we_cpu     (we_cpu),
    .we_snd     (we_snd),
    .we_gfx     (we_gfx),
    .we_prom    (we_prom),
    .core_reset (core_reset),
    .load_done  (load_done),
    .load_err   (load_err),
    .byte_count (byte_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Address map: region k covers [base[k], next base); anything at or past ImgEnd is rejected.
  function automatic void ref_decode(input logic [24:0] a, output bit ok,
                                     output logic [3:0] we, output logic [15:0] rel);
    int unsigned base [4];
    base = '{32'h0, 32'h4000, 32'h5800, 32'h6800};
    ok   = (32'(a) < ImgEnd);
    we   = 4'b0000;
    rel  = 16'h0000;
    if (ok) begin
      for (int i = 0; i < 4; i++) begin
        if (32'(a) >= base[i]) begin
          we  = 4'(1 << i);
          rel = 16'(32'(a) - base[i]);
        end
      end
    end
  endfunction

  task automatic model_reset();
    prev_dl = 1'b0;
    m_count = 17'd0;
    m_addr  = 16'h0000;
    m_data  = 8'h00;
  endtask

  // One clock: drive inputs, advance past the edge, then check the write path against the model.
  task automatic step(input logic dl, input logic wr, input logic [24:0] a, input logic [7:0] d);
    bit          ok;
    bit          acc;
    logic [3:0]  we_e;
    logic [15:0] rel;
    dn_download = dl;
    dn_wr       = wr;
    dn_addr     = a;
    dn_data     = d;
    @(posedge clk);
    #1;
    acc = wr && (dl || prev_dl);
    if (dl && !prev_dl) m_count = 17'd0;
    ref_decode(a, ok, we_e, rel);
    if (acc && ok) begin
      m_addr = rel;
      m_data = d;
      if (m_count != 17'h1FFFF) m_count = m_count + 17'd1;
    end else begin
      we_e = 4'b0000;
    end
    prev_dl = dl;
    check("we", {28'd0, we_prom, we_gfx, we_snd, we_cpu}, {28'd0, we_e});
    check("wr_addr", {16'd0, wr_addr}, {16'd0, m_addr});
    check("wr_data", {24'd0, wr_data}, {24'd0, m_data});
    check("byte_count", {15'd0, byte_count}, {15'd0, m_count});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 25'($urandom), 8'($urandom));
  endtask

  // Sequential download of n bytes; the last strobe coincides with the window closing.
  task automatic download(input int n, input bit gaps, input bit extras);
    for (int i = 0; i < n - 1; i++) begin
      if (gaps && $urandom_range(31) == 0) step(1'b1, 1'b0, 25'($urandom), 8'($urandom));
      step(1'b1, 1'b1, 25'(i), 8'($urandom));
      if (i == 0) begin
        check("flags_clear_done", {31'd0, load_done}, 32'd0);
        check("flags_clear_err", {31'd0, load_err}, 32'd0);
      end
      if (extras && i == 100) begin
        step(1'b1, 1'b1, 25'h0007000, 8'($urandom));
        step(1'b1, 1'b1, 25'h0010000, 8'($urandom));
      end
    end
    step(1'b0, 1'b1, 25'(n - 1), 8'($urandom));
  endtask

  task automatic reset_values(input string tag);
    check({tag, "_core_reset"}, {31'd0, core_reset}, 32'd1);
    check({tag, "_we"}, {28'd0, we_prom, we_gfx, we_snd, we_cpu}, 32'd0);
    check({tag, "_wr_addr"}, {16'd0, wr_addr}, 32'd0);
    check({tag, "_wr_data"}, {24'd0, wr_data}, 32'd0);
    check({tag, "_done"}, {31'd0, load_done}, 32'd0);
    check({tag, "_err"}, {31'd0, load_err}, 32'd0);
    check({tag, "_count"}, {15'd0, byte_count}, 32'd0);
  endtask

  initial begin
    RESET_N     = 1'b0;
    dn_download = 1'b0;
    dn_wr       = 1'b0;
    dn_addr     = '0;
    dn_data     = '0;
    ext_reset   = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset_values("por");
    RESET_N = 1'b1;
    idle(4);
    check("idle_core_reset", {31'd0, core_reset}, 32'd1);

    // Reset pulse in the middle of a download, then a complete good load.
    for (int i = 0; i < 'h100; i++) step(1'b1, 1'b1, 25'(i), 8'($urandom));
    #2;
    RESET_N     = 1'b0;
    dn_download = 1'b0;
    dn_wr       = 1'b0;
    #1;
    reset_values("mid_reset");
    model_reset();
    @(posedge clk);
    #1;
    reset_values("mid_reset_hold");
    RESET_N = 1'b1;
    idle(8);
    check("post_reset_core_reset", {31'd0, core_reset}, 32'd1);

    download(ImgEnd, 1'b1, 1'b0);
    for (int k = 1; k <= 17; k++) begin
      step(1'b0, 1'b0, 25'($urandom), 8'($urandom));
      if (k == 1) check("good_done", {31'd0, load_done}, 32'd1);
      check("good_release", {31'd0, core_reset}, (k < 17) ? 32'd1 : 32'd0);
    end
    check("good_err", {31'd0, load_err}, 32'd0);
    check("good_count", {15'd0, byte_count}, ImgEnd);

    // Strobes outside a download window are ignored.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 25'($urandom_range(ImgEnd - 1)), 8'($urandom));
    check("run_core_reset", {31'd0, core_reset}, 32'd0);

    // User reset in RUN: held 5 cycles, released 16 cycles after it falls.
    ext_reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      idle(1);
      check("ext_hold", {31'd0, core_reset}, 32'd1);
    end
    ext_reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      idle(1);
      check("ext_release", {31'd0, core_reset}, (k < 16) ? 32'd1 : 32'd0);
    end

    // Short image: error, core stays in reset, user reset ignored.
    download(32'h6000, 1'b0, 1'b0);
    idle(2);
    check("short_err", {31'd0, load_err}, 32'd1);
    check("short_done", {31'd0, load_done}, 32'd0);
    ext_reset = 1'b1;
    idle(3);
    ext_reset = 1'b0;
    idle(30);
    check("short_core_reset", {31'd0, core_reset}, 32'd1);

    // Full image plus out-of-range bytes: no strobes for them, count exact, still an error.
    download(ImgEnd, 1'b0, 1'b1);
    idle(2);
    check("oor_count", {15'd0, byte_count}, ImgEnd);
    check("oor_err", {31'd0, load_err}, 32'd1);
    check("oor_done", {31'd0, load_done}, 32'd0);
    idle(30);
    check("oor_core_reset", {31'd0, core_reset}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
